fsm_step_driver: RTL and testbench
==================================

# fsm_step_driver

Transmit-side companion to the 7-state stepping FSM. The stepping FSM advances one state on a `1` bit, wrapping G to A, and retreats one state on a `0` bit, saturating at A. On request, this block emits the shortest serial bit sequence that steers that FSM from its current state to a requested target state. It keeps an internal mirror of the consumer's state and sits directly upstream of the consumer's `input_bit`. The consumer steps only on cycles where `tx_valid` is high.

## Interface
- `GAP`, default 0: idle cycles inserted after each transmitted bit, with `tx_valid` low during them. Legal range 0–15.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: request strobe, accepted only when `ready`=1.
- `target` in 3: requested state code, 0=A … 6=G, sampled when `start` is accepted.
- `ready` out 1: block is idle and will accept `start`.
- `tx_bit` out 1: serial step bit; 1=advance, 0=retreat.
- `tx_valid` out 1: `tx_bit` is valid this cycle, and the consumer steps.
- `mirror_state` out 3: the block's copy of the consumer state.
- `done` out 1: 1-cycle pulse when the mirror equals the accepted target.
- `err` out 1: 1-cycle pulse when an illegal target (7) is rejected.

## Operation
- States: IDLE, PLAN, SEND, WAIT, DONE, ERR.
- IDLE:
  - `ready`=1.
  - On `start`, latch `target` to `tgt`, then go to PLAN.
  - With `start`=0, stay in IDLE.
- PLAN (1 cycle), with c = `mirror_state`:
  - If `tgt`=7, go to ERR.
  - Forward distance f = (tgt − c) mod 7.
  - Backward distance b = c − tgt when tgt ≤ c; otherwise backward is not possible, because retreat saturates at A.
  - If f=0 (same state), go to DONE with no bits sent.
  - Otherwise choose backward when b exists and b < f; else forward. A tie is impossible, since f + b = 7 when tgt < c.
  - Load `cnt` (3 bits) with the chosen distance and latch the direction `dir`.
  - Go to SEND.
- SEND (1 cycle per bit):
  - `tx_valid`=1 and `tx_bit`=`dir`.
  - `mirror_state` updates at the end of the cycle: forward 6→0, otherwise +1; backward −1.
  - Decrement `cnt`.
  - If `cnt` becomes 0, go to DONE.
  - Otherwise go to WAIT when `GAP`>0, or stay in SEND.
- WAIT:
  - Count `GAP` cycles with `tx_valid`=0, then return to SEND.
  - The gap counter is 4 bits.
  - No gap is inserted after the final bit.
- DONE: `done`=1 for one cycle, then go to IDLE.
- ERR: `err`=1 for one cycle, then go to IDLE. `mirror_state` is unchanged and no bits are sent.
- `start` outside IDLE is ignored and is not queued.
- When `tx_valid`=0, `tx_bit` is driven 0.

## Timing
- Reset values:
  - State IDLE.
  - `ready`=1.
  - `tx_bit`=0, `tx_valid`=0.
  - `mirror_state`=0 (A).
  - `done`=0, `err`=0.
  - `cnt`=0.
- Reset asserted mid-operation aborts the sequence on that edge. No further `tx_valid` occurs, and the mirror returns to A. The consumer must be reset at the same time.
- Accept edge = the cycle where `start`=1 and `ready`=1.
  - `ready` falls the next cycle.
  - PLAN occupies cycle +1.
  - The first `tx_valid` is at cycle +2.
- Sequence of N bits:
  - The last `tx_valid` is at cycle +2 + (N−1)(1+GAP).
  - `done` is high the following cycle.
  - `ready` returns to 1 one cycle after `done`.
- Zero distance: `done` at cycle +2, `ready` at +3.
- Illegal target: `err` at cycle +2, `ready` at +3.
- Maximum N = 6 (forward) or 3 (backward-preferred). Worst-case N is 6, e.g. A→G forward.
- All outputs are registered. No combinational path from inputs to outputs.

## Test plan
- After reset, `start`, `target`=6, `GAP`=0: six `tx_valid` cycles with `tx_bit`=1 at cycles +2..+7; `mirror_state` ends at 6; `done` at +8.
- From `mirror_state`=5, `target`=2: three bits with `tx_bit`=0 (backward, b=3 < f=4); mirror goes 4, 3, 2; then `done`.
- From 6, `target`=0: a single `1` bit (wrap G→A); mirror=0; `done` at +3. From 4, `target`=0: three `1` bits, since f=3 < b=4.
- `target`=3 equal to the mirror: no `tx_valid`, `done` at +2. `target`=7: `err` at +2, mirror unchanged, no bits.
- `GAP`=2, from 0 to 3: `tx_valid` at +2, +5, +8; `done` at +9; `start` pulses during the sequence are ignored.
- Reset asserted after the second bit of a 0→5 sequence: `tx_valid`=0 from the next cycle, `mirror_state`=0, `ready`=1. A new request 0→1 afterwards completes normally.

Source files
------------

// File: rtl/fsm_step_driver.sv
// fsm_step_driver
// Drives the serial input of a 7-state stepping FSM (A..G, codes 0..6).
// The consumer advances on a 1 bit, wrapping G to A, and retreats on a
// 0 bit, saturating at A. On request this block sends the shortest bit
// sequence that moves the consumer from its current state to a target.
// It keeps a mirror copy of the consumer state to plan each move.
//
// Ports:
//   clk          - rising-edge clock
//   reset        - synchronous, active-high
//   start        - request strobe, accepted only while ready=1
//   target       - requested state code, 0..6 (7 is rejected)
//   ready        - idle and able to accept start
//   tx_bit       - step bit (1=advance, 0=retreat), 0 when tx_valid=0
//   tx_valid     - tx_bit is valid; the consumer steps this cycle
//   mirror_state - local copy of the consumer state
//   done         - one-cycle pulse when the mirror reaches the target
//   err          - one-cycle pulse when target 7 is rejected
// Parameter GAP (0..15): idle cycles inserted between transmitted bits.

module fsm_step_driver #(
  parameter int GAP = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] target,
  output logic       ready,
  output logic       tx_bit,
  output logic       tx_valid,
  output logic [2:0] mirror_state,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {IDLE, PLAN, SEND, WAIT, DONE, ERR} state_t;

  localparam logic [3:0] GAP_W = 4'(GAP);

  state_t     state, state_nx;
  logic [2:0] tgt, tgt_nx;
  logic [2:0] cnt, cnt_nx;
  logic [2:0] mirror_nx;
  logic       dir, dir_nx;
  logic [3:0] gcnt, gcnt_nx;

  logic [3:0] fwd_dist;
  logic [3:0] bwd_dist;
  logic       use_bwd;

  // Distances from the mirror to the latched target. Forward distance is
  // taken modulo 7 because advancing wraps G to A. Retreating saturates at
  // A, so going backward only works when the target lies below the mirror.
  // The two distances sum to 7 in that case, so they can never tie.
  always_comb begin
    if (tgt >= mirror_state)
      fwd_dist = {1'b0, tgt} - {1'b0, mirror_state};
    else
      fwd_dist = {1'b0, tgt} + 4'd7 - {1'b0, mirror_state};
    bwd_dist = {1'b0, mirror_state} - {1'b0, tgt};
    use_bwd  = (tgt < mirror_state) && (bwd_dist < fwd_dist);
  end

  // Next-state and next-datapath logic. Every register holds by default;
  // each state overrides only what it changes.
  always_comb begin
    state_nx  = state;
    tgt_nx    = tgt;
    cnt_nx    = cnt;
    dir_nx    = dir;
    gcnt_nx   = gcnt;
    mirror_nx = mirror_state;
    unique case (state)
      IDLE: begin
        if (start) begin
          tgt_nx   = target;
          state_nx = PLAN;
        end
      end
      PLAN: begin
        if (tgt == 3'd7) begin
          state_nx = ERR;
        end else if (fwd_dist == 4'd0) begin
          state_nx = DONE;
        end else begin
          dir_nx   = ~use_bwd;
          cnt_nx   = use_bwd ? bwd_dist[2:0] : fwd_dist[2:0];
          state_nx = SEND;
        end
      end
      SEND: begin
        // The planner never asks for a retreat from A, so the backward
        // step needs no saturation here.
        if (dir)
          mirror_nx = (mirror_state == 3'd6) ? 3'd0 : mirror_state + 3'd1;
        else
          mirror_nx = mirror_state - 3'd1;
        cnt_nx = cnt - 3'd1;
        if (cnt == 3'd1) begin
          state_nx = DONE;
        end else if (GAP > 0) begin
          gcnt_nx  = GAP_W;
          state_nx = WAIT;
        end
      end
      WAIT: begin
        if (gcnt <= 4'd1)
          state_nx = SEND;
        else
          gcnt_nx = gcnt - 4'd1;
      end
      DONE:    state_nx = IDLE;
      ERR:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State and datapath registers. Outputs are decoded from the next state
  // and registered here so that each one changes together with the state
  // it describes and no input reaches an output combinationally.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      tgt          <= 3'd0;
      cnt          <= 3'd0;
      dir          <= 1'b0;
      gcnt         <= 4'd0;
      mirror_state <= 3'd0;
      ready        <= 1'b1;
      tx_valid     <= 1'b0;
      tx_bit       <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      state        <= state_nx;
      tgt          <= tgt_nx;
      cnt          <= cnt_nx;
      dir          <= dir_nx;
      gcnt         <= gcnt_nx;
      mirror_state <= mirror_nx;
      ready        <= (state_nx == IDLE);
      tx_valid     <= (state_nx == SEND);
      tx_bit       <= (state_nx == SEND) && dir_nx;
      done         <= (state_nx == DONE);
      err          <= (state_nx == ERR);
    end
  end

endmodule

// File: tb/tb_fsm_step_driver.sv
// tb_fsm_step_driver
// Self-checking bench for fsm_step_driver. Two instances are used: one
// with GAP=0 for the main vector table and the reset-abort sequence, and
// one with GAP=2 for bit spacing and ignored start pulses. A small
// cycle-by-cycle model built from the step count, direction and gap gives
// the expected tx_valid/tx_bit/mirror/done/err/ready on every cycle.

module tb_fsm_step_driver;

  logic       clk = 1'b0;
  logic       reset;
  logic       start0, start1;
  logic [2:0] target0, target1;
  logic       ready0, ready1;
  logic       tx_bit0, tx_bit1;
  logic       tx_valid0, tx_valid1;
  logic [2:0] mirror0, mirror1;
  logic       done0, done1;
  logic       err0, err1;

  int errors = 0;
  int checks = 0;
  int mdl[2];

  typedef struct {
    logic [2:0] tgt;
    int         n;
    logic       dir;
    logic       is_err;
    int         exp_mirror;
  } vec_t;

  vec_t vecs[11];

  always #5 clk = ~clk;

  fsm_step_driver #(.GAP(0)) u_dut0 (
    .clk(clk), .reset(reset), .start(start0), .target(target0),
    .ready(ready0), .tx_bit(tx_bit0), .tx_valid(tx_valid0),
    .mirror_state(mirror0), .done(done0), .err(err0)
  );

  fsm_step_driver #(.GAP(2)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .target(target1),
    .ready(ready1), .tx_bit(tx_bit1), .tx_valid(tx_valid1),
    .mirror_state(mirror1), .done(done1), .err(err1)
  );

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string name, input int cyc,
                             input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Read the outputs of the selected instance.
  task automatic sampleOut(input int sel, output logic r, output logic tb,
                           output logic tv, output logic [2:0] m,
                           output logic d, output logic e);
    if (sel == 0) begin
      r = ready0; tb = tx_bit0; tv = tx_valid0; m = mirror0; d = done0; e = err0;
    end else begin
      r = ready1; tb = tx_bit1; tv = tx_valid1; m = mirror1; d = done1; e = err1;
    end
  endtask

  task automatic driveStart(input int sel, input logic s, input logic [2:0] t);
    if (sel == 0) begin
      start0 = s; target0 = t;
    end else begin
      start1 = s; target1 = t;
    end
  endtask

  // Issue one request and check every cycle until ready returns.
  // n/dir are the hand-planned step count and direction for the move.
  task automatic applyStimulus(input int sel, input logic [2:0] tgt,
                               input int n, input logic dir,
                               input logic is_err, input bit pulse);
    int   gap, m, done_cyc, end_cyc;
    logic exp_valid;
    logic r, tb, tv, d, e;
    logic [2:0] mo;
    gap = (sel == 0) ? 0 : 2;
    m   = mdl[sel];
    if (is_err || n == 0) done_cyc = 2;
    else                  done_cyc = 2 + (n - 1) * (1 + gap) + 1;
    end_cyc = done_cyc + 1;
    @(negedge clk);
    driveStart(sel, 1'b1, tgt);
    for (int c = 1; c <= end_cyc; c++) begin
      @(negedge clk);
      sampleOut(sel, r, tb, tv, mo, d, e);
      exp_valid = (n > 0) && (c >= 2) && (((c - 2) % (1 + gap)) == 0) &&
                  (((c - 2) / (1 + gap)) < n);
      checkOutput("ready",    c, {3'b0, r},  {3'b0, (c == end_cyc)});
      checkOutput("tx_valid", c, {3'b0, tv}, {3'b0, exp_valid});
      checkOutput("tx_bit",   c, {3'b0, tb}, {3'b0, exp_valid & dir});
      checkOutput("mirror",   c, {1'b0, mo}, 4'(m));
      checkOutput("done",     c, {3'b0, d},  {3'b0, (c == done_cyc) && !is_err});
      checkOutput("err",      c, {3'b0, e},  {3'b0, (c == 2) && is_err});
      if (exp_valid) m = dir ? ((m == 6) ? 0 : m + 1) : m - 1;
      if (pulse && c < end_cyc - 1)
        driveStart(sel, 1'b1, 3'($urandom_range(0, 7)));
      else
        driveStart(sel, 1'b0, 3'd0);
    end
    if (pulse) begin
      @(negedge clk);
      sampleOut(sel, r, tb, tv, mo, d, e);
      checkOutput("no_queued_start_ready", end_cyc + 1, {3'b0, r},  4'd1);
      checkOutput("no_queued_start_valid", end_cyc + 1, {3'b0, tv}, 4'd0);
    end
    mdl[sel] = m;
  endtask

  task automatic doReset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    mdl[0] = 0;
    mdl[1] = 0;
  endtask

  initial begin
    logic r, tb, tv, d, e;
    logic [2:0] mo;

    // Moves on the GAP=0 instance, chained from the reset state A.
    vecs[0]  = '{3'd6, 6, 1'b1, 1'b0, 6};
    vecs[1]  = '{3'd0, 1, 1'b1, 1'b0, 0};
    vecs[2]  = '{3'd5, 5, 1'b1, 1'b0, 5};
    vecs[3]  = '{3'd2, 3, 1'b0, 1'b0, 2};
    vecs[4]  = '{3'd4, 2, 1'b1, 1'b0, 4};
    vecs[5]  = '{3'd0, 3, 1'b1, 1'b0, 0};
    vecs[6]  = '{3'd3, 3, 1'b1, 1'b0, 3};
    vecs[7]  = '{3'd3, 0, 1'b1, 1'b0, 3};
    vecs[8]  = '{3'd7, 0, 1'b1, 1'b1, 3};
    vecs[9]  = '{3'd6, 3, 1'b1, 1'b0, 6};
    vecs[10] = '{3'd3, 3, 1'b0, 1'b0, 3};

    start0 = 1'b0; start1 = 1'b0; target0 = 3'd0; target1 = 3'd0;
    doReset();

    for (int s = 0; s < 2; s++) begin
      sampleOut(s, r, tb, tv, mo, d, e);
      checkOutput("rst_ready",    0, {3'b0, r},  4'd1);
      checkOutput("rst_tx_valid", 0, {3'b0, tv}, 4'd0);
      checkOutput("rst_tx_bit",   0, {3'b0, tb}, 4'd0);
      checkOutput("rst_mirror",   0, {1'b0, mo}, 4'd0);
      checkOutput("rst_done",     0, {3'b0, d},  4'd0);
      checkOutput("rst_err",      0, {3'b0, e},  4'd0);
    end

    for (int i = 0; i < 11; i++) begin
      applyStimulus(0, vecs[i].tgt, vecs[i].n, vecs[i].dir, vecs[i].is_err, 1'b0);
      checkOutput("vec_final_mirror", i, {1'b0, mirror0}, 4'(vecs[i].exp_mirror));
    end

    // GAP=2: bits spaced three cycles apart, start pulses ignored.
    applyStimulus(1, 3'd3, 3, 1'b1, 1'b0, 1'b1);
    checkOutput("gap_final_mirror", 0, {1'b0, mirror1}, 4'd3);
    applyStimulus(1, 3'd1, 2, 1'b0, 1'b0, 1'b0);
    checkOutput("gap_back_mirror", 0, {1'b0, mirror1}, 4'd1);

    // Reset mid-sequence: abort a 0->5 move after its second bit.
    doReset();
    @(negedge clk);
    driveStart(0, 1'b1, 3'd5);
    @(negedge clk);
    driveStart(0, 1'b0, 3'd0);
    @(negedge clk);
    checkOutput("abort_bit1", 2, {3'b0, tx_valid0}, 4'd1);
    @(negedge clk);
    checkOutput("abort_bit2", 3, {3'b0, tx_valid0}, 4'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    mdl[0] = 0;
    mdl[1] = 0;
    checkOutput("abort_tx_valid", 4, {3'b0, tx_valid0}, 4'd0);
    checkOutput("abort_mirror",   4, {1'b0, mirror0},   4'd0);
    checkOutput("abort_ready",    4, {3'b0, ready0},    4'd1);
    @(negedge clk);
    checkOutput("abort_quiet",    5, {3'b0, tx_valid0}, 4'd0);
    applyStimulus(0, 3'd1, 1, 1'b1, 1'b0, 1'b0);
    checkOutput("after_abort_mirror", 0, {1'b0, mirror0}, 4'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
